wb_traffic_chk: RTL and testbench

Parametrised Wishbone B3 master that writes a deterministic, address-derived pattern into the memory controller and reads it back, comparing every beat. It is the synthesisable successor to the fixed per-port bench masters. One instance attaches to any `wb_adr_i_N`/`wb_dat_i_N` port group of the memory controller. It supports classic, incrementing-burst and wrapping-burst modes, and adds an error count, a first-failure capture and an ack watchdog.

---
 rtl/wb_traffic_chk_if.sv | 26 ++
 rtl/wb_traffic_chk.sv | 196 +++++++++++++++++++
 tb/tb_wb_traffic_chk.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_traffic_chk_if.sv
// Wishbone B3 bus bundle between the traffic checker (master) and the
// memory controller port it exercises (slave).
//   adr_o/dat_o/sel_o/we_o/cti_o/bte_o/cyc_o/stb_o : master -> slave
//   dat_i/ack_i                                    : slave  -> master
interface wb_traffic_chk_if ();
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic        we_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic        cyc_o;
    logic        stb_o;
    logic [31:0] dat_i;
    logic        ack_i;

    modport master (
        output adr_o, dat_o, sel_o, we_o, cti_o, bte_o, cyc_o, stb_o,
        input  dat_i, ack_i
    );

    modport slave (
        input  adr_o, dat_o, sel_o, we_o, cti_o, bte_o, cyc_o, stb_o,
        output dat_i, ack_i
    );
endinterface

// File: rtl/wb_traffic_chk.sv
// Wishbone B3 traffic checker: writes an address-derived pattern over
// NR_OF_BURSTS bursts, reads it back and compares every beat.
//   wb_clk, wb_rst_n : clock, asynchronous active-low reset
//   start            : one-cycle pulse, starts a run from IDLE or DONE
//   bus              : Wishbone master port (adr/dat/sel/we/cti/bte/cyc/stb, dat_i/ack_i)
//   done, ok, timeout: run finished / run passed / ack watchdog fired
//   err_cnt          : saturating count of mismatching read beats
//   first_err_adr    : address of the first mismatching read beat
module wb_traffic_chk #(
    parameter logic [31:0] BASE_ADR     = 32'h0000_0000,
    parameter int unsigned NR_OF_BURSTS = 16,
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned MODE         = 1,
    parameter int unsigned START_OFS    = 1,
    parameter logic [31:0] SEED         = 32'hA5A5_5A5A,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic                    start,
    wb_traffic_chk_if.master        bus,
    output logic                    done,
    output logic                    ok,
    output logic                    timeout,
    output logic [15:0]             err_cnt,
    output logic [31:0]             first_err_adr
);
    localparam int unsigned BEAT_W  = $clog2(BURST_LEN);
    localparam int unsigned BURST_W = 16;
    localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [1:0]  BTE     = (MODE != 2)      ? 2'b00 :
                                      (BURST_LEN == 4) ? 2'b01 :
                                      (BURST_LEN == 8) ? 2'b10 : 2'b11;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WR     = 3'd1;
    localparam logic [2:0] WR_GAP = 3'd2;
    localparam logic [2:0] RD     = 3'd3;
    localparam logic [2:0] RD_GAP = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]         state_q, state_d;
    logic               start_q;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [31:0]        adr_q, adr_d, dat_q, dat_d;
    logic               we_q, we_d, cyc_q, cyc_d;
    logic [2:0]         cti_q, cti_d;
    logic [1:0]         bte_q, bte_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [31:0]        first_err_q, first_err_d;
    logic               timeout_q, timeout_d, done_q, done_d, ok_q, ok_d;
    logic               ack_beat, last_beat, last_burst, active;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ SEED ^ {a[15:0], a[31:16]};
    endfunction

    // Byte address of beat k of burst b; MODE 2 wraps the offset inside the block.
    function automatic logic [31:0] beat_adr(input logic [BURST_W-1:0] b,
                                             input logic [BEAT_W-1:0] k);
        logic [BEAT_W-1:0] ofs;
        ofs = (MODE == 2) ? k + BEAT_W'(START_OFS) : k;
        return BASE_ADR + 32'(b) * 32'(BURST_LEN * 4) + (32'(ofs) << 2);
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        burst_d     = burst_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        timeout_d   = timeout_q;
        ack_beat    = cyc_q && bus.ack_i;
        last_beat   = beat_q == BEAT_W'(BURST_LEN - 1);
        last_burst  = burst_q == BURST_W'(NR_OF_BURSTS - 1);

        case (state_q)
            IDLE, DONE: begin
                if (start_q) begin
                    state_d     = WR;
                    beat_d      = '0;
                    burst_d     = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            WR, RD: begin
                if (ack_beat) begin
                    if (state_q == RD && bus.dat_i != pat(adr_q)) begin
                        if (err_cnt_q == 16'h0000) first_err_d = adr_q;
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (last_beat) state_d = (state_q == WR) ? WR_GAP : RD_GAP;
                    else           beat_d  = beat_q + BEAT_W'(1);
                end else if (cyc_q && wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            WR_GAP: begin
                beat_d = '0;
                if (last_burst) begin
                    state_d = RD;
                    burst_d = '0;
                end else begin
                    state_d = WR;
                    burst_d = burst_q + BURST_W'(1);
                end
            end
            RD_GAP: begin
                beat_d = '0;
                if (last_burst) begin
                    state_d = DONE;
                end else begin
                    state_d = RD;
                    burst_d = burst_q + BURST_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog restarts on any ack or state change and only counts while strobing.
        if (ack_beat || state_d != state_q) wd_d = '0;
        else if (cyc_q)                     wd_d = wd_q + WD_W'(1);
        else                                wd_d = wd_q;

        // MODE 0 drops the strobe for one cycle after every ack.
        active = (state_d == WR) || (state_d == RD);
        cyc_d  = active && !(MODE == 0 && ack_beat);
        adr_d  = cyc_d ? beat_adr(burst_d, beat_d) : adr_q;
        we_d   = cyc_d && (state_d == WR);
        dat_d  = we_d ? pat(adr_d) : 32'h0;
        if (cyc_d && MODE != 0) cti_d = (beat_d == BEAT_W'(BURST_LEN - 1)) ? 3'b111 : 3'b010;
        else                    cti_d = 3'b000;
        bte_d  = cyc_d ? BTE : 2'b00;
        done_d = state_d == DONE;
        ok_d   = done_d && err_cnt_d == 16'h0000 && !timeout_d;
    end

    // State and output registers.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            beat_q      <= '0;
            burst_q     <= '0;
            wd_q        <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            cti_q       <= 3'b000;
            bte_q       <= 2'b00;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            beat_q      <= beat_d;
            burst_q     <= burst_d;
            wd_q        <= wd_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            cti_q       <= cti_d;
            bte_q       <= bte_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
        end
    end

    assign bus.adr_o     = adr_q;
    assign bus.dat_o     = dat_q;
    assign bus.sel_o     = 4'hF;
    assign bus.we_o      = we_q;
    assign bus.cti_o     = cti_q;
    assign bus.bte_o     = bte_q;
    assign bus.cyc_o     = cyc_q;
    assign bus.stb_o     = cyc_q;
    assign done          = done_q;
    assign ok            = ok_q;
    assign timeout       = timeout_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_adr = first_err_q;
endmodule

// File: tb/tb_wb_traffic_chk.sv
// Bench for wb_traffic_chk: three instances (incrementing, wrapping, classic)
// each on a memory slave with optional wait states, no-ack and read corruption.
module tb_wb_traffic_chk;
    localparam int NDUT = 3;
    localparam int          P_MODE [NDUT] = '{1, 2, 0};
    localparam int          P_BL   [NDUT] = '{4, 4, 8};
    localparam int          P_NB   [NDUT] = '{2, 2, 2};
    localparam int          P_SOFS [NDUT] = '{1, 1, 1};
    localparam logic [31:0] P_BASE [NDUT] = '{32'h100, 32'h100, 32'h200};
    localparam logic [31:0] P_SEED = 32'hA5A5_5A5A;
    localparam int          P_TO   = 16;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a   [NDUT];
    logic        noack_a   [NDUT];
    logic        rnd_a     [NDUT];
    logic        corrupt_a [NDUT];
    logic        done_a [NDUT], ok_a [NDUT], to_a [NDUT];
    logic [15:0] err_a [NDUT];
    logic [31:0] fea_a [NDUT];
    logic        cyc_a [NDUT], stb_a [NDUT], we_a [NDUT];
    logic [31:0] adr_a [NDUT], dat_a [NDUT];
    logic [2:0]  cti_a [NDUT];
    logic [1:0]  bte_a [NDUT];
    logic [3:0]  sel_a [NDUT];
    int unsigned stab_err [NDUT] = '{0, 0, 0};
    int unsigned b2b      [NDUT] = '{0, 0, 0};
    beat_t       mon_q [NDUT][$];
    beat_t       exp_q [$];
    int          tests = 0;
    int          fails = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        wb_traffic_chk_if bus ();
        logic [31:0] mem [0:255];
        int unsigned wcnt;
        logic        ack_w;
        logic        prev_wait = 1'b0;
        logic        prev_ack = 1'b0;
        logic [66:0] prev_snap = '0;
        beat_t       b;

        wb_traffic_chk #(
            .BASE_ADR(P_BASE[g]), .NR_OF_BURSTS(P_NB[g]), .BURST_LEN(P_BL[g]),
            .MODE(P_MODE[g]), .START_OFS(P_SOFS[g]), .SEED(P_SEED), .TIMEOUT(P_TO)
        ) u_dut (
            .wb_clk(clk), .wb_rst_n(rst_n), .start(start_a[g]), .bus(bus),
            .done(done_a[g]), .ok(ok_a[g]), .timeout(to_a[g]),
            .err_cnt(err_a[g]), .first_err_adr(fea_a[g])
        );

        assign cyc_a[g] = bus.cyc_o;
        assign stb_a[g] = bus.stb_o;
        assign we_a[g]  = bus.we_o;
        assign adr_a[g] = bus.adr_o;
        assign dat_a[g] = bus.dat_o;
        assign cti_a[g] = bus.cti_o;
        assign bte_a[g] = bus.bte_o;
        assign sel_a[g] = bus.sel_o;

        // Memory slave with optional random wait states and a corrupted read at 0x108.
        assign ack_w     = bus.cyc_o && bus.stb_o && !noack_a[g] && (wcnt == 0);
        assign bus.ack_i = ack_w;
        assign bus.dat_i = mem[bus.adr_o[9:2]] ^
                           ((corrupt_a[g] && !bus.we_o && bus.adr_o == 32'h108) ? 32'h1 : 32'h0);

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wcnt <= 0;
            end else if (bus.cyc_o && bus.stb_o) begin
                if (ack_w) begin
                    if (bus.we_o) mem[bus.adr_o[9:2]] <= bus.dat_o;
                    wcnt <= rnd_a[g] ? $urandom_range(3, 0) : 0;
                end else if (wcnt != 0) begin
                    wcnt <= wcnt - 1;
                end
            end
        end

        // Bus monitor: logs accepted beats, stability while waiting, and back-to-back cycles.
        always @(negedge clk) begin
            if (rst_n && bus.cyc_o && bus.stb_o) begin
                if (prev_wait && {bus.adr_o, bus.dat_o, bus.cti_o} !== prev_snap)
                    stab_err[g] = stab_err[g] + 1;
                if (ack_w) begin
                    b = '{adr: bus.adr_o, dat: bus.dat_o, we: bus.we_o, cti: bus.cti_o, bte: bus.bte_o};
                    mon_q[g].push_back(b);
                end
                prev_wait = !ack_w;
                prev_snap = {bus.adr_o, bus.dat_o, bus.cti_o};
            end else begin
                prev_wait = 1'b0;
            end
            if (rst_n && prev_ack && bus.cyc_o) b2b[g] = b2b[g] + 1;
            prev_ack = rst_n && bus.cyc_o && bus.stb_o && ack_w;
        end
    end

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ P_SEED ^ {a[15:0], a[31:16]};
    endfunction

    // Reference bus trace: all write beats, then all read beats, from the addressing rules.
    task automatic build_exp(input int g);
        beat_t e;
        int    ofs;
        exp_q.delete();
        for (int ph = 0; ph < 2; ph++)
            for (int bi = 0; bi < P_NB[g]; bi++)
                for (int k = 0; k < P_BL[g]; k++) begin
                    ofs   = (P_MODE[g] == 2) ? (P_SOFS[g] + k) % P_BL[g] : k;
                    e.adr = P_BASE[g] + 32'(bi * P_BL[g] * 4 + ofs * 4);
                    e.we  = (ph == 0);
                    e.dat = e.we ? pat(e.adr) : 32'h0;
                    e.cti = (P_MODE[g] == 0) ? 3'b000 : (k == P_BL[g] - 1) ? 3'b111 : 3'b010;
                    e.bte = (P_MODE[g] != 2) ? 2'b00 : (P_BL[g] == 4) ? 2'b01 :
                            (P_BL[g] == 8) ? 2'b10 : 2'b11;
                    exp_q.push_back(e);
                end
    endtask

    // Pulse start and wait (bounded) for done; n = cycles from the start edge.
    task automatic run(input int g, output int n);
        @(negedge clk);
        start_a[g] = 1'b1;
        @(posedge clk);
        #1 start_a[g] = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (done_a[g] !== 1'b1 && n < 3000);
    endtask

    task automatic test_reset();
        for (int g = 0; g < NDUT; g++) begin
            tests++;
            if ({cyc_a[g], stb_a[g], we_a[g]} !== 3'b000) begin
                fails++; $display("FAIL reset_bus g%0d: cyc/stb/we=%b expected 000", g, {cyc_a[g], stb_a[g], we_a[g]});
            end
            tests++;
            if ({done_a[g], ok_a[g], to_a[g]} !== 3'b000) begin
                fails++; $display("FAIL reset_status g%0d: done/ok/timeout=%b expected 000", g, {done_a[g], ok_a[g], to_a[g]});
            end
            tests++;
            if (adr_a[g] !== 32'h0 || dat_a[g] !== 32'h0) begin
                fails++; $display("FAIL reset_adr_dat g%0d: adr=%h dat=%h expected 0", g, adr_a[g], dat_a[g]);
            end
            tests++;
            if (err_a[g] !== 16'h0 || fea_a[g] !== 32'h0) begin
                fails++; $display("FAIL reset_err g%0d: err_cnt=%h first_err_adr=%h expected 0", g, err_a[g], fea_a[g]);
            end
            tests++;
            if ({sel_a[g], cti_a[g], bte_a[g]} !== {4'hF, 3'b000, 2'b00}) begin
                fails++; $display("FAIL reset_sel g%0d: sel=%h cti=%b bte=%b expected F/000/00", g, sel_a[g], cti_a[g], bte_a[g]);
            end
        end
    endtask

    task automatic test_incr();
        int n, base;
        base = mon_q[0].size();
        run(0, n);
        tests++;
        if (n !== 21) begin fails++; $display("FAIL incr_latency: %0d cycles expected 21", n); end
        tests++;
        if ({done_a[0], ok_a[0], err_a[0]} !== {2'b11, 16'h0}) begin
            fails++; $display("FAIL incr_status: done=%b ok=%b err=%0d expected 1/1/0", done_a[0], ok_a[0], err_a[0]);
        end
        build_exp(0);
        tests++;
        if (mon_q[0].size() - base != exp_q.size()) begin
            fails++; $display("FAIL incr_beats: %0d beats expected %0d", mon_q[0].size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < mon_q[0].size(); i++) begin
            tests++;
            if (mon_q[0][base + i] !== exp_q[i]) begin
                fails++; $display("FAIL incr_beat%0d: got %h expected %h", i, mon_q[0][base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int n, base;
        logic [31:0] first_adr [4] = '{32'h104, 32'h108, 32'h10C, 32'h100};
        base = mon_q[1].size();
        run(1, n);
        tests++;
        if (n !== 21 || ok_a[1] !== 1'b1) begin
            fails++; $display("FAIL wrap_run: %0d cycles ok=%b expected 21/1", n, ok_a[1]);
        end
        for (int k = 0; k < 4 && base + k < mon_q[1].size(); k++) begin
            tests++;
            if (mon_q[1][base + k].adr !== first_adr[k] || mon_q[1][base + k].bte !== 2'b01 ||
                mon_q[1][base + k].cti !== ((k == 3) ? 3'b111 : 3'b010)) begin
                fails++; $display("FAIL wrap_first%0d: adr=%h cti=%b bte=%b expected adr=%h", k,
                    mon_q[1][base + k].adr, mon_q[1][base + k].cti, mon_q[1][base + k].bte, first_adr[k]);
            end
        end
        build_exp(1);
        tests++;
        if (mon_q[1].size() - base != exp_q.size()) begin
            fails++; $display("FAIL wrap_beats: %0d beats expected %0d", mon_q[1].size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < mon_q[1].size(); i++) begin
            tests++;
            if (mon_q[1][base + i] !== exp_q[i]) begin
                fails++; $display("FAIL wrap_beat%0d: got %h expected %h", i, mon_q[1][base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_classic();
        int n, base;
        int unsigned b0;
        base = mon_q[2].size();
        b0   = b2b[2];
        run(2, n);
        tests++;
        if (n !== 65 || ok_a[2] !== 1'b1) begin
            fails++; $display("FAIL classic_run: %0d cycles ok=%b expected 65/1", n, ok_a[2]);
        end
        tests++;
        if (b2b[2] - b0 != 0) begin
            fails++; $display("FAIL classic_gap: %0d cycles with cyc right after ack expected 0", b2b[2] - b0);
        end
        build_exp(2);
        tests++;
        if (mon_q[2].size() - base != exp_q.size()) begin
            fails++; $display("FAIL classic_beats: %0d beats expected %0d", mon_q[2].size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < mon_q[2].size(); i++) begin
            tests++;
            if (mon_q[2][base + i] !== exp_q[i]) begin
                fails++; $display("FAIL classic_beat%0d: got %h expected %h", i, mon_q[2][base + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        noack_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b1;
        @(posedge clk);
        #1 start_a[0] = 1'b0;
        n = 0;
        while (stb_a[0] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        tests++;
        if (n !== 1) begin fails++; $display("FAIL timeout_launch: stb after %0d cycles expected 1", n); end
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (done_a[0] !== 1'b1 && n < 100);
        tests++;
        if (n !== P_TO) begin fails++; $display("FAIL timeout_delay: done %0d cycles after stb expected %0d", n, P_TO); end
        tests++;
        if ({to_a[0], ok_a[0], done_a[0], cyc_a[0], stb_a[0]} !== 5'b10100) begin
            fails++; $display("FAIL timeout_status: timeout/ok/done/cyc/stb=%b expected 10100",
                {to_a[0], ok_a[0], done_a[0], cyc_a[0], stb_a[0]});
        end
        noack_a[0] = 1'b0;
    endtask

    task automatic test_corrupt();
        int n;
        corrupt_a[0] = 1'b1;
        run(0, n);
        corrupt_a[0] = 1'b0;
        tests++;
        if (err_a[0] !== 16'd1 || fea_a[0] !== 32'h108) begin
            fails++; $display("FAIL corrupt_err: err_cnt=%0d first_err_adr=%h expected 1/108", err_a[0], fea_a[0]);
        end
        tests++;
        if ({done_a[0], ok_a[0], to_a[0]} !== 3'b100) begin
            fails++; $display("FAIL corrupt_status: done/ok/timeout=%b expected 100", {done_a[0], ok_a[0], to_a[0]});
        end
    endtask

    task automatic test_random_wait();
        int n, base;
        int unsigned s0;
        for (int rep = 0; rep < 2; rep++)
            for (int g = 0; g < NDUT; g++) begin
                rnd_a[g] = 1'b1;
                base = mon_q[g].size();
                s0   = stab_err[g];
                run(g, n);
                rnd_a[g] = 1'b0;
                tests++;
                if ({done_a[g], ok_a[g]} !== 2'b11 || stab_err[g] != s0) begin
                    fails++; $display("FAIL rwait_g%0d: done=%b ok=%b unstable=%0d expected 1/1/0",
                        g, done_a[g], ok_a[g], stab_err[g] - s0);
                end
                build_exp(g);
                tests++;
                if (mon_q[g].size() - base != exp_q.size()) begin
                    fails++; $display("FAIL rwait_beats_g%0d: %0d beats expected %0d", g, mon_q[g].size() - base, exp_q.size());
                end
                for (int i = 0; i < exp_q.size() && base + i < mon_q[g].size(); i++) begin
                    tests++;
                    if (mon_q[g][base + i] !== exp_q[i]) begin
                        fails++; $display("FAIL rwait_g%0d_beat%0d: got %h expected %h", g, i, mon_q[g][base + i], exp_q[i]);
                    end
                end
            end
    endtask

    task automatic test_reset_mid();
        int n, base;
        @(negedge clk);
        start_a[0] = 1'b1;
        @(posedge clk);
        #1 start_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (cyc_a[0] !== 1'b1) begin fails++; $display("FAIL rstmid_pre: cyc=%b expected 1", cyc_a[0]); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({cyc_a[0], stb_a[0], we_a[0], cti_a[0], bte_a[0]} !== 8'h00 || adr_a[0] !== 32'h0 || dat_a[0] !== 32'h0) begin
            fails++; $display("FAIL rstmid_bus: cyc=%b stb=%b we=%b cti=%b bte=%b adr=%h dat=%h expected all 0",
                cyc_a[0], stb_a[0], we_a[0], cti_a[0], bte_a[0], adr_a[0], dat_a[0]);
        end
        tests++;
        if ({done_a[0], ok_a[0], to_a[0]} !== 3'b000 || err_a[0] !== 16'h0 || sel_a[0] !== 4'hF) begin
            fails++; $display("FAIL rstmid_status: done/ok/timeout=%b err=%0d sel=%h expected 000/0/F",
                {done_a[0], ok_a[0], to_a[0]}, err_a[0], sel_a[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = mon_q[0].size();
        run(0, n);
        tests++;
        if ({done_a[0], ok_a[0]} !== 2'b11 || n !== 21) begin
            fails++; $display("FAIL rstmid_rerun: done=%b ok=%b cycles=%0d expected 1/1/21", done_a[0], ok_a[0], n);
        end
        build_exp(0);
        for (int i = 0; i < exp_q.size(); i++) begin
            tests++;
            if (base + i >= mon_q[0].size() || mon_q[0][base + i] !== exp_q[i]) begin
                fails++; $display("FAIL rstmid_beat%0d: expected %h", i, exp_q[i]);
            end
        end
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            start_a[g]   = 1'b0;
            noack_a[g]   = 1'b0;
            rnd_a[g]     = 1'b0;
            corrupt_a[g] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_incr();
        test_wrap();
        test_classic();
        test_timeout();
        test_corrupt();
        test_random_wait();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "bench stalled");
    end
endmodule
